als_muldiv_unit: RTL and testbench



---
 rtl/als_muldiv_unit_if.sv | 28 ++
 rtl/als_muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_als_muldiv_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/als_muldiv_unit_if.sv
// Request/result bundle for the iterative multiply/divide engine.
// Defining ALS_MULDIV_ABORT_EN adds the abort request line.
interface als_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] lhs;
   logic [WIDTH-1:0] rhs;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;
`ifdef ALS_MULDIV_ABORT_EN
   logic             abort;

   modport master (output start, op, lhs, rhs, abort,
                   input  busy, done, hi, lo, div_zero);
   modport slave  (input  start, op, lhs, rhs, abort,
                   output busy, done, hi, lo, div_zero);
`else
   modport master (output start, op, lhs, rhs,
                   input  busy, done, hi, lo, div_zero);
   modport slave  (input  start, op, lhs, rhs,
                   output busy, done, hi, lo, div_zero);
`endif
endinterface

// File: rtl/als_muldiv_unit.sv
// Iterative signed/unsigned multiply (radix-2 shift-add) and restoring divide, HI/LO results.
// Optional ALS_MULDIV_ABORT_EN lets an in-flight operation be cancelled back to IDLE.
module als_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic              Clk,
   input logic              reset,
   als_muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic             is_div;
   logic             neg_res;
   logic             neg_rem;
   logic             zero_div;
   logic [WIDTH:0]   rem_acc;
   logic [WIDTH-1:0] low_q;
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic             div_zero_reg;

   logic             accept;
   logic             abort_hit;
   logic             signed_op;
   logic             lhs_neg;
   logic             rhs_neg;
   logic [WIDTH-1:0] lhs_mag;
   logic [WIDTH-1:0] rhs_mag;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [2*WIDTH-1:0] prod_raw;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   assign accept = bus.start && (state == S_IDLE || state == S_DONE);

`ifdef ALS_MULDIV_ABORT_EN
   assign abort_hit = bus.abort && (state == S_CALC || state == S_FIX);
`else
   assign abort_hit = 1'b0;
`endif

   // Operands are reduced to magnitudes at accept; signs are reapplied in FIX.
   assign signed_op = ~bus.op[0];
   assign lhs_neg   = signed_op && bus.lhs[WIDTH-1];
   assign rhs_neg   = signed_op && bus.rhs[WIDTH-1];
   assign lhs_mag   = lhs_neg ? -bus.lhs : bus.lhs;
   assign rhs_mag   = rhs_neg ? -bus.rhs : bus.rhs;

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_CALC;
         S_CALC:  if (count == '0) state_next = S_FIX;
         S_FIX:   state_next = S_DONE;
         S_DONE:  state_next = accept ? S_CALC : S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (abort_hit) state_next = S_IDLE;
   end

   always_comb begin
      bus.busy     = (state == S_CALC) || (state == S_FIX);
      bus.done     = (state == S_DONE);
      bus.hi       = hi_reg;
      bus.lo       = lo_reg;
      bus.div_zero = div_zero_reg;
   end

   // A borrow out of the WIDTH+1 bit trial subtract means the divisor did not fit.
   always_comb begin
      mul_sum   = rem_acc + {1'b0, (low_q[0] ? opnd_b : {WIDTH{1'b0}})};
      div_shift = {rem_acc[WIDTH-1:0], low_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_b};
   end

   always_comb begin
      prod_raw = {rem_acc[WIDTH-1:0], low_q};
      prod_fix = neg_res ? -prod_raw : prod_raw;
      quo_fix  = zero_div ? {WIDTH{1'b1}} : (neg_res ? -low_q : low_q);
      rem_fix  = neg_rem ? -rem_acc[WIDTH-1:0] : rem_acc[WIDTH-1:0];
   end

   // For a zero divisor the remainder path reconstructs the original dividend.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         count        <= '0;
         is_div       <= 1'b0;
         neg_res      <= 1'b0;
         neg_rem      <= 1'b0;
         zero_div     <= 1'b0;
         rem_acc      <= '0;
         low_q        <= '0;
         opnd_b       <= '0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         div_zero_reg <= 1'b0;
      end else if (accept) begin
         count        <= CNT_W'(WIDTH);
         is_div       <= bus.op[1];
         neg_res      <= lhs_neg ^ rhs_neg;
         neg_rem      <= lhs_neg;
         zero_div     <= bus.op[1] && (bus.rhs == '0);
         rem_acc      <= '0;
         low_q        <= bus.op[1] ? lhs_mag : rhs_mag;
         opnd_b       <= bus.op[1] ? rhs_mag : lhs_mag;
         div_zero_reg <= 1'b0;
      end else if (state == S_CALC && count != '0) begin
         count <= count - CNT_W'(1);
         if (is_div) begin
            if (!div_trial[WIDTH]) begin
               rem_acc <= div_trial;
               low_q   <= {low_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_acc <= div_shift;
               low_q   <= {low_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            rem_acc <= {1'b0, mul_sum[WIDTH:1]};
            low_q   <= {mul_sum[0], low_q[WIDTH-1:1]};
         end
      end else if (state == S_FIX && !abort_hit) begin
         if (is_div) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
         end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
         end
         div_zero_reg <= zero_div;
      end
   end

endmodule

// File: tb/tb_als_muldiv_unit.sv
// Scoreboard bench for als_muldiv_unit: stimulus pushes expected HI/LO/div_zero and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_als_muldiv_unit;

   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 2;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          done_cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   als_muldiv_unit_if #(.WIDTH(WIDTH)) bus();

   als_muldiv_unit #(.WIDTH(WIDTH)) dut (
      .Clk   (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives a start pulse in the current cycle; the accept happens on the next rising edge.
   task automatic driveStart(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                             input logic edz, input bit track);
      exp_t e;
      bus.start = 1'b1;
      bus.op    = op;
      bus.lhs   = a;
      bus.rhs   = b;
      if (track) begin
         e.name     = name;
         e.hi       = eh;
         e.lo       = el;
         e.dz       = edz;
         e.done_cyc = cyc + 1 + LAT;
         sb.push_back(e);
      end
   endtask

   task automatic releaseStart();
      bus.start = 1'b0;
      bus.op    = 2'b10;
      bus.lhs   = 32'hDEAD_BEEF;
      bus.rhs   = 32'h0000_0000;
   endtask

   task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                                input logic edz, input bit track);
      @(negedge clock);
      driveStart(name, op, a, b, eh, el, edz, track);
      @(negedge clock);
      releaseStart();
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(negedge clock);
      end
      checkOutput("drain_pending", sb.size(), 0);
      sb.delete();
      @(negedge clock);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset && bus.done) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_hi"}, bus.hi, e.hi);
            checkOutput({e.name, "_lo"}, bus.lo, e.lo);
            checkOutput({e.name, "_div_zero"}, bus.div_zero, e.dz);
            checkOutput({e.name, "_done_cycle"}, cyc, e.done_cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.lhs   = '0;
      bus.rhs   = '0;
`ifdef ALS_MULDIV_ABORT_EN
      bus.abort = 1'b0;
`endif
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("reset_busy", bus.busy, 0);
      checkOutput("reset_done", bus.done, 0);
      checkOutput("reset_hi", bus.hi, 0);
      checkOutput("reset_lo", bus.lo, 0);
      checkOutput("reset_div_zero", bus.div_zero, 0);
      reset = 1'b1;

      applyStimulus("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1);
      checkOutput("busy_in_calc", bus.busy, 1);
      waitDrain();
      applyStimulus("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);
      waitDrain();
      applyStimulus("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
      waitDrain();
      applyStimulus("multu_zero", OP_MULTU, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
      waitDrain();
      applyStimulus("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
      waitDrain();
      applyStimulus("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
      waitDrain();
      applyStimulus("div_7_neg2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b1);
      waitDrain();
      applyStimulus("divu_100_3", OP_DIVU, 32'h0000_0064, 32'h0000_0003, 32'h0000_0001, 32'h0000_0021, 1'b0, 1'b1);
      waitDrain();

      applyStimulus("divu_by_zero", OP_DIVU, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1, 1'b1);
      waitDrain();
      applyStimulus("multu_after_dz", OP_MULTU, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b1);
      checkOutput("dz_cleared_at_accept", bus.div_zero, 0);
      waitDrain();
      applyStimulus("div_neg5_by_zero", OP_DIV, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b1);
      waitDrain();

      // Back-to-back: second start is presented during the DONE cycle of the first.
      applyStimulus("b2b_first", OP_MULTU, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0, 1'b1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.done) begin
               seen = 1'b1;
               break;
            end
         end
         checkOutput("b2b_first_done_seen", seen, 1);
         driveStart("b2b_second", OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1);
         @(negedge clock);
         releaseStart();
         checkOutput("b2b_busy", bus.busy, 1);
      end
      waitDrain();

      // A start pulse while busy must not disturb the running multiply.
      applyStimulus("multu_7x9", OP_MULTU, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 32'h0000_003F, 1'b0, 1'b1);
      repeat (3) @(negedge clock);
      driveStart("ignored_divu", OP_DIVU, 32'h0000_0064, 32'h0000_0003, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clock);
      releaseStart();
      waitDrain();

      applyStimulus("reset_victim", OP_MULTU, 32'h0000_0005, 32'h0000_0005, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (8) @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("midop_reset_busy", bus.busy, 0);
      checkOutput("midop_reset_done", bus.done, 0);
      checkOutput("midop_reset_hi", bus.hi, 0);
      checkOutput("midop_reset_lo", bus.lo, 0);
      checkOutput("midop_reset_div_zero", bus.div_zero, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (LAT + 5) @(negedge clock);
      checkOutput("post_reset_busy", bus.busy, 0);
      checkOutput("post_reset_lo", bus.lo, 0);

`ifdef ALS_MULDIV_ABORT_EN
      applyStimulus("pre_abort_7x9", OP_MULTU, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 32'h0000_003F, 1'b0, 1'b1);
      waitDrain();
      applyStimulus("aborted_mult", OP_MULT, 32'h0000_0004, 32'h0000_0004, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(negedge clock);
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      checkOutput("abort_busy", bus.busy, 0);
      checkOutput("abort_done", bus.done, 0);
      checkOutput("abort_hi_kept", bus.hi, 0);
      checkOutput("abort_lo_kept", bus.lo, 32'h0000_003F);
      driveStart("after_abort", OP_MULTU, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0, 1'b1);
      @(negedge clock);
      releaseStart();
      checkOutput("after_abort_busy", bus.busy, 1);
      waitDrain();
`endif

      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
